// File: rtl/counter_load.sv
// Run-time-loadable down-counter: dn rises n+1 enabled cycles after a load.
// Define COUNTER_LOAD_PERIODIC_EN to add the per input and auto-reload mode.
module counter_load #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] n,
  input  logic             en,
`ifdef COUNTER_LOAD_PERIODIC_EN
  input  logic             per,
`endif
  output logic             dn,
  output logic             busy,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] c_reg, c_next;
  logic             busy_reg, busy_next;
  logic             dn_reg, dn_next;
  logic             periodic;
  logic [WIDTH-1:0] period;

`ifdef COUNTER_LOAD_PERIODIC_EN
  logic [WIDTH-1:0] p_reg;

  assign periodic = per;
  assign period   = p_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_reg <= '0;
    end else if (ld) begin
      p_reg <= n;
    end
  end
`else
  assign periodic = 1'b0;
  assign period   = '0;
`endif

  always_comb begin
    c_next    = c_reg;
    busy_next = busy_reg;
    dn_next   = dn_reg;
    if (ld) begin
      c_next    = n;
      busy_next = 1'b1;
      dn_next   = 1'b0;
    end else if (busy_reg) begin
      // In RUN a periodic pulse always clears, even on a paused edge.
      dn_next = 1'b0;
      if (en) begin
        if (c_reg != '0) begin
          c_next = c_reg - WIDTH'(1);
        end else if (periodic) begin
          c_next  = period;
          dn_next = 1'b1;
        end else begin
          busy_next = 1'b0;
          dn_next   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_reg    <= '0;
      busy_reg <= 1'b0;
      dn_reg   <= 1'b0;
    end else begin
      c_reg    <= c_next;
      busy_reg <= busy_next;
      dn_reg   <= dn_next;
    end
  end

  assign cnt  = c_reg;
  assign busy = busy_reg;
  assign dn   = dn_reg;

endmodule
